// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// FSM states and IR field positions.
package ctrl_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;
  localparam int FIELD_W = 4;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHL  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_ADDI = 5'd8;
  localparam logic [4:0] OP_ANDI = 5'd9;
  localparam logic [4:0] OP_ORI  = 5'd10;
  localparam logic [4:0] OP_LD   = 5'd12;
  localparam logic [4:0] OP_ST   = 5'd13;
  localparam logic [4:0] OP_BR   = 5'd16;
  localparam logic [4:0] OP_NOP  = 5'd30;
  localparam logic [4:0] OP_HALT = 5'd31;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHL = 4'd4;
  localparam logic [3:0] ALU_SHR = 4'd5;

  typedef enum logic [3:0] {
    RESET, F0, F1, F2, E3, E4, E5, E6, E7, HALT
  } state_t;

  function automatic logic is_rtype(input logic [4:0] op);
    return op <= OP_SHR;
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LD, OP_ST, OP_BR,
      OP_NOP, OP_HALT: ok = 1'b1;
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Immediate forms reuse the ALU function of their register counterpart;
  // address arithmetic (LD/ST/BR) falls through to ADD.
  function automatic logic [3:0] alu_for(input logic [4:0] op);
    logic [3:0] f;
    case (op)
      OP_SUB:          f = ALU_SUB;
      OP_AND, OP_ANDI: f = ALU_AND;
      OP_OR, OP_ORI:   f = ALU_OR;
      OP_SHL:          f = ALU_SHL;
      OP_SHR:          f = ALU_SHR;
      default:         f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath/memory signal bundle; master is the sequencer.
interface control_sequencer_if #(
  parameter int NUM_REGS = 16
);
  logic [31:0]         ir;
  logic                con_ff;
  logic                mem_done;
  logic [NUM_REGS-1:0] rin;
  logic [NUM_REGS-1:0] rout;
  logic                pc_in, pc_out, inc_pc;
  logic                mar_in, mdr_in, mdr_out;
  logic                mem_read, mem_write;
  logic                ir_in, y_in, z_in, z_out, c_out, con_in;
  logic [3:0]          alu_op;
  logic                run;
  logic                fault;

  modport master (
    input  ir, con_ff, mem_done,
    output rin, rout, pc_in, pc_out, inc_pc, mar_in, mdr_in, mdr_out,
           mem_read, mem_write, ir_in, y_in, z_in, z_out, c_out, con_in,
           alu_op, run, fault
  );

  modport slave (
    output ir, con_ff, mem_done,
    input  rin, rout, pc_in, pc_out, inc_pc, mar_in, mdr_in, mdr_out,
           mem_read, mem_write, ir_in, y_in, z_in, z_out, c_out, con_in,
           alu_op, run, fault
  );
endinterface

// File: rtl/reg_select_decoder.sv
// Decodes a register field to a one-hot select; fields beyond NUM_REGS select nothing.
module reg_select_decoder #(
  parameter int NUM_REGS = 16,
  parameter int FIELD_W  = 4
) (
  input  logic [FIELD_W-1:0]  field,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = en && (int'(field) == i);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: fetch, decode and
// multi-cycle execute with a timed memory handshake.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                 clock,
  input logic                 clear,
  control_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   wait_cnt;
  logic               fault_q;
  logic [4:0]         op;
  logic [FIELD_W-1:0] ra, rb, rc;
  logic               in_wait, timeout;
  logic [FIELD_W-1:0] rin_field, rout_field;
  logic               rin_en, rout_en;
  logic               unused_ir_low;

  assign op            = bus.ir[OP_MSB:OP_LSB];
  assign ra            = bus.ir[RA_MSB:RA_LSB];
  assign rb            = bus.ir[RB_MSB:RB_LSB];
  assign rc            = bus.ir[RC_MSB:RC_LSB];
  assign unused_ir_low = ^bus.ir[RC_LSB-1:0];

  assign in_wait = (state == F1) || (state == E6 && op == OP_LD) ||
                   (state == E7 && op == OP_ST);
  assign timeout = in_wait && !bus.mem_done &&
                   (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  // The wait counter idles at zero outside wait states, so each wait starts fresh.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= RESET;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_wait && !bus.mem_done) wait_cnt <= wait_cnt + 1'b1;
      else                          wait_cnt <= '0;
      if (timeout || (state == F2 && !is_legal(op))) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RESET: state_nx = F0;
      F0:    state_nx = F1;
      F1:    if (timeout) state_nx = HALT;
             else if (bus.mem_done) state_nx = F2;
      F2:    if (!is_legal(op) || op == OP_HALT) state_nx = HALT;
             else if (op == OP_NOP) state_nx = F0;
             else state_nx = E3;
      E3:    state_nx = E4;
      E4:    state_nx = E5;
      E5:    state_nx = (is_rtype(op) || is_imm(op)) ? F0 : E6;
      E6:    if (op == OP_LD) begin
               if (timeout) state_nx = HALT;
               else if (bus.mem_done) state_nx = E7;
             end else if (op == OP_ST) state_nx = E7;
             else state_nx = F0;
      E7:    if (op == OP_ST) begin
               if (timeout) state_nx = HALT;
               else if (bus.mem_done) state_nx = F0;
             end else state_nx = F0;
      HALT:  state_nx = HALT;
      default: state_nx = RESET;
    endcase
  end

  always_comb begin
    rin_field     = ra;
    rin_en        = 1'b0;
    rout_field    = rb;
    rout_en       = 1'b0;
    bus.pc_in     = 1'b0;
    bus.pc_out    = 1'b0;
    bus.inc_pc    = 1'b0;
    bus.mar_in    = 1'b0;
    bus.mdr_in    = 1'b0;
    bus.mdr_out   = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_in     = 1'b0;
    bus.y_in      = 1'b0;
    bus.z_in      = 1'b0;
    bus.z_out     = 1'b0;
    bus.c_out     = 1'b0;
    bus.con_in    = 1'b0;
    bus.alu_op    = ALU_ADD;
    case (state)
      F0: begin
        bus.pc_out = 1'b1; bus.mar_in = 1'b1; bus.inc_pc = 1'b1; bus.z_in = 1'b1;
      end
      F1: begin
        bus.z_out = 1'b1; bus.mem_read = 1'b1; bus.mdr_in = 1'b1;
        bus.pc_in = bus.mem_done;
      end
      F2: begin
        bus.mdr_out = 1'b1; bus.ir_in = 1'b1;
      end
      E3: begin
        rout_en = 1'b1;
        if (op == OP_BR) begin
          rout_field = ra; bus.con_in = 1'b1;
        end else begin
          bus.y_in = 1'b1;
        end
      end
      E4: begin
        if (op == OP_BR) begin
          bus.pc_out = 1'b1; bus.y_in = 1'b1;
        end else begin
          if (is_rtype(op)) begin
            rout_en = 1'b1; rout_field = rc;
          end else begin
            bus.c_out = 1'b1;
          end
          bus.alu_op = alu_for(op);
          bus.z_in   = 1'b1;
        end
      end
      E5: begin
        if (op == OP_BR) begin
          bus.c_out = 1'b1; bus.z_in = 1'b1;
        end else begin
          bus.z_out  = 1'b1;
          rin_en     = is_rtype(op) || is_imm(op);
          bus.mar_in = !rin_en;
        end
      end
      E6: begin
        if (op == OP_LD) begin
          bus.mem_read = 1'b1; bus.mdr_in = 1'b1;
        end else if (op == OP_ST) begin
          rout_en = 1'b1; rout_field = ra; bus.mdr_in = 1'b1;
        end else begin
          bus.z_out = 1'b1; bus.pc_in = bus.con_ff;
        end
      end
      E7: begin
        if (op == OP_LD) begin
          bus.mdr_out = 1'b1; rin_en = 1'b1;
        end else begin
          bus.mem_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.run   = (state != RESET) && (state != HALT);
  assign bus.fault = fault_q;

  reg_select_decoder #(.NUM_REGS(NUM_REGS), .FIELD_W(FIELD_W)) u_rin_sel (
    .field (rin_field),
    .en    (rin_en),
    .sel   (bus.rin)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS), .FIELD_W(FIELD_W)) u_rout_sel (
    .field (rout_field),
    .en    (rout_en),
    .sel   (bus.rout)
  );

endmodule
